// File: rtl/aes_result_uart_tx.sv
// aes_result_uart_tx: sends a captured 128-bit AES result over a UART line.
// The message is 32 uppercase ASCII hex digits, most significant nibble first,
// followed by CR LF. Each character is framed 8N1. Characters follow each
// other with no gap cycles between them.
module aes_result_uart_tx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         send,
    output logic         busy,
    output logic         done,
    output logic         tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0] CHAR_CR   = 6'd32;
    localparam logic [5:0] CHAR_LAST = 6'd33;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [5:0]         r_char_idx, w_char_idx_nxt;
    logic [127:0]       r_data, w_data_nxt;
    logic               r_tx, w_tx_nxt;
    logic               r_done, w_done_nxt;

    logic [3:0]         w_nibble;
    logic [7:0]         w_char;
    logic               w_bit_end;

    // Select the character currently being sent from the character index.
    always_comb begin
        // Character i uses nibble 31-i, i.e. the bitwise inverse of the low 5 index bits.
        w_nibble = r_data[{~r_char_idx[4:0], 2'b00} +: 4];
        if (r_char_idx == CHAR_CR) begin
            w_char = 8'h0D;
        end else if (r_char_idx == CHAR_LAST) begin
            w_char = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_char = 8'h37 + {4'h0, w_nibble};
        end
    end

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Next-state logic: bit timing, bit/character sequencing and the serial output value.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_char_idx_nxt = r_char_idx;
        w_data_nxt     = r_data;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;

        case (r_state)
            StIdle: begin
                w_tx_nxt = 1'b1;
                if (send) begin
                    // tx drops on the accepting edge itself.
                    w_state_nxt    = StStart;
                    w_data_nxt     = data_in;
                    w_tx_nxt       = 1'b0;
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_char_idx_nxt = '0;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_tx_nxt       = w_char[0];
                    w_state_nxt    = StData;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = StStop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_char[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_char_idx == CHAR_LAST) begin
                        w_char_idx_nxt = '0;
                        w_done_nxt     = 1'b1;
                        w_tx_nxt       = 1'b1;
                        w_state_nxt    = StIdle;
                    end else begin
                        // Next start bit begins immediately: no gap between characters.
                        w_char_idx_nxt = r_char_idx + 6'd1;
                        w_tx_nxt       = 1'b0;
                        w_state_nxt    = StStart;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // State register with synchronous active-high reset; reset aborts any message.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_char_idx <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_char_idx <= w_char_idx_nxt;
            r_data     <= w_data_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign tx   = r_tx;

endmodule
